// File: rtl/sim_watchdog_pkg.sv
// rtl/sim_watchdog_pkg.sv - shared types and defaults for the simulation watchdog
// Contents: wd_state_e state/status encoding, default cycle parameters,
//           is_terminal() helper used by the FSM and the finish pulse.
package sim_watchdog_pkg;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    HOLD      = 3'd1,
    RUN       = 3'd2,
    PASS      = 3'd3,
    FAIL      = 3'd4,
    TO_GLOBAL = 3'd5,
    TO_IDLE   = 3'd6
  } wd_state_e;

  localparam int DEF_RST_HOLD_CYCLES = 8;
  localparam int DEF_GLOBAL_TIMEOUT  = 100000;
  localparam int DEF_IDLE_TIMEOUT    = 1000;
  localparam int DEF_CNT_W           = 32;

  function automatic logic is_terminal(input wd_state_e s);
    return (s == PASS) || (s == FAIL) || (s == TO_GLOBAL) || (s == TO_IDLE);
  endfunction

endpackage

// File: rtl/sim_watchdog_rst_sync.sv
// rtl/sim_watchdog_rst_sync.sv - 2-flop async-assert / sync-deassert reset synchronizer
// Ports: ck       in  clock
//        rst_n    in  raw asynchronous active-low reset
//        rst_sync out synchronized release (0 while in reset, 1 two edges after release)
module rst_sync (
  input  logic ck,
  input  logic rst_n,
  output logic rst_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = 1'b1;
    sync_d = meta_q;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rst_sync = sync_q;

endmodule

// File: rtl/sim_watchdog.sv
// rtl/sim_watchdog.sv - reset sequencer, run supervisor and verdict generator for the dut
// Ports: ck          in  clock
//        rst_n       in  asynchronous active-low reset
//        dut_rst     out synchronous active-high reset to the dut
//        heartbeat   in  dut progress pulse (RUN only)
//        done        in  dut completion strobe (RUN only)
//        pass        in  dut result, qualified by done
//        finish      out one-cycle pulse on entry to a terminal state
//        status      out current wd_state_e
//        cycle_count out RUN cycles elapsed, frozen once terminal
module sim_watchdog
  import sim_watchdog_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int GLOBAL_TIMEOUT  = DEF_GLOBAL_TIMEOUT,
  parameter int IDLE_TIMEOUT    = DEF_IDLE_TIMEOUT,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             ck,
  input  logic             rst_n,
  output logic             dut_rst,
  input  logic             heartbeat,
  input  logic             done,
  input  logic             pass,
  output logic             finish,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycle_count
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GLOBAL_LAST = CNT_W'(GLOBAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  IDLE_LAST   = CNT_W'(IDLE_TIMEOUT - 1);

  if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("sim_watchdog: RST_HOLD_CYCLES must be >= 1");
  end
  if ((GLOBAL_TIMEOUT < 1) || (longint'(GLOBAL_TIMEOUT) > CNT_MAX)) begin : g_bad_global
    $error("sim_watchdog: GLOBAL_TIMEOUT out of range for CNT_W");
  end
  if ((IDLE_TIMEOUT < 1) || (longint'(IDLE_TIMEOUT) > CNT_MAX)) begin : g_bad_idle
    $error("sim_watchdog: IDLE_TIMEOUT out of range for CNT_W");
  end

  logic rst_sync_w;

  rst_sync u_rst_sync (
    .ck       (ck),
    .rst_n    (rst_n),
    .rst_sync (rst_sync_w)
  );

  wd_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic              dut_rst_q, dut_rst_d;
  logic              finish_q, finish_d;

  // State register plus the counters and registered outputs.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      hold_q    <= '0;
      cycle_q   <= '0;
      idle_q    <= '0;
      dut_rst_q <= 1'b1;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cycle_q   <= cycle_d;
      idle_q    <= idle_d;
      dut_rst_q <= dut_rst_d;
      finish_q  <= finish_d;
    end
  end

  // Next state. In RUN, done outranks the global timeout, which outranks idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC: if (rst_sync_w) state_d = HOLD;
      HOLD: if (hold_q == HOLD_LAST) state_d = RUN;
      RUN: begin
        if (done)                                  state_d = pass ? PASS : FAIL;
        else if (cycle_q == GLOBAL_LAST)           state_d = TO_GLOBAL;
        else if (!heartbeat && idle_q == IDLE_LAST) state_d = TO_IDLE;
      end
      default: state_d = state_q;
    endcase
  end

  // Counters. cycle_count only moves in RUN, so it freezes on the decision edge
  // with the deciding cycle included.
  always_comb begin
    hold_d  = '0;
    cycle_d = cycle_q;
    idle_d  = '0;
    if (state_q == HOLD && hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end
    if (state_q == RUN) begin
      if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
      if (!heartbeat)    idle_d  = (idle_q != '1) ? idle_q + 1'b1 : idle_q;
    end
  end

  // Outputs, registered from the next state so they change with status.
  always_comb begin
    dut_rst_d = (state_d != RUN);
    finish_d  = is_terminal(state_d) && !is_terminal(state_q);
  end

  assign dut_rst     = dut_rst_q;
  assign finish      = finish_q;
  assign status      = state_q;
  assign cycle_count = cycle_q;

  a_pass_known : assert property (@(posedge ck) disable iff (!rst_n)
    (state_q == RUN && done) |-> !$isunknown(pass));

endmodule
